// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ
// frame producers; each grant carries one complete BURST_LEN-word frame.
`default_nettype none

module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int BURST_LEN  = 80
) (
  input  logic                          clk_wr,
  input  logic                          rst_wr_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            src_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] src_data,
  output logic [NUM_REQ-1:0]            src_ready,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  input  logic [ADDR_WIDTH-1:0]         fifo_count,
  output logic                          burst_done,
  output logic [$clog2(NUM_REQ)-1:0]    owner
);

  localparam int DEPTH   = 2**ADDR_WIDTH;
  localparam int OWNER_W = $clog2(NUM_REQ);
  localparam int CNT_W   = $clog2(BURST_LEN+1);
  localparam logic [ADDR_WIDTH:0] SPACE_LIMIT = (ADDR_WIDTH+1)'(DEPTH - BURST_LEN);
  localparam logic [CNT_W-1:0]    LAST_BEAT   = CNT_W'(BURST_LEN - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [NUM_REQ-1:0]   gnt_nxt;
  logic [OWNER_W-1:0]   owner_nxt;
  logic [OWNER_W-1:0]   last_owner, last_owner_nxt;
  logic [CNT_W-1:0]     beat_cnt, beat_cnt_nxt;
  logic                 burst_done_nxt;
  logic                 space_ok;
  logic                 accept;
  logic                 found;
  logic [OWNER_W-1:0]   winner;

  // fifo_count lags reads, so this admits a frame only when it certainly fits.
  assign space_ok = ~fifo_full & ({1'b0, fifo_count} <= SPACE_LIMIT);

  // Round-robin search starting just after the previous owner.
  always_comb begin
    int                 idx;
    logic [OWNER_W-1:0] cand;
    found  = 1'b0;
    winner = last_owner;
    idx    = 0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx  = (int'(last_owner) + k) % NUM_REQ;
      cand = OWNER_W'(idx);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    fifo_wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == OWNER_W'(i)) begin
        fifo_wr_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    beat_cnt_nxt   = beat_cnt;
    burst_done_nxt = 1'b0;
    src_ready      = '0;
    accept         = 1'b0;
    fifo_wr_en     = 1'b0;

    case (state)
      IDLE: begin
        if (found && space_ok) begin
          state_nxt       = BURST;
          gnt_nxt         = '0;
          gnt_nxt[winner] = 1'b1;
          owner_nxt       = winner;
          beat_cnt_nxt    = '0;
        end
      end
      BURST: begin
        src_ready[owner] = ~fifo_full;
        accept           = src_valid[owner] & ~fifo_full;
        fifo_wr_en       = accept;
        if (accept) begin
          if (beat_cnt == LAST_BEAT) begin
            state_nxt      = IDLE;
            gnt_nxt        = '0;
            last_owner_nxt = owner;
            beat_cnt_nxt   = '0;
            burst_done_nxt = 1'b1;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state      <= IDLE;
      gnt        <= '0;
      owner      <= '0;
      last_owner <= OWNER_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
      burst_done <= burst_done_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter
// (4 sources, 256-deep FIFO, 80-word frames).
`default_nettype none

module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int BL = 80;

  logic              clk_wr = 1'b0;
  logic              rst_wr_n;
  logic [NR-1:0]     req;
  logic [NR-1:0]     src_valid;
  logic [NR*DW-1:0]  src_data;
  logic [NR-1:0]     src_ready;
  logic [NR-1:0]     gnt;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic              fifo_full;
  logic [AW-1:0]     fifo_count;
  logic              burst_done;
  logic [1:0]        owner;

  logic [23:0]       wcnt [NR];
  int                total = 0;
  int                bad   = 0;

  fifo_wr_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)
  ) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .req(req), .src_valid(src_valid),
    .src_data(src_data), .src_ready(src_ready), .gnt(gnt),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_full(fifo_full), .fifo_count(fifo_count),
    .burst_done(burst_done), .owner(owner)
  );

  always #5 clk_wr = ~clk_wr;

  // Source i streams words tagged with its index in the top byte.
  always_comb begin
    for (int i = 0; i < NR; i++) src_data[i*DW +: DW] = {8'(i), wcnt[i]};
  end

  function automatic logic [NR-1:0] oh(input int o);
    oh = NR'(1) << o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk_wr);
    rst_wr_n = 1'b0; req = '0; src_valid = '0; fifo_full = 1'b0; fifo_count = '0;
    @(negedge clk_wr);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_done", 32'(burst_done), 0);
    chk("rst_ready", 32'(src_ready), 0);
    chk("rst_wr_en", 32'(fifo_wr_en), 0);
    @(negedge clk_wr);
    rst_wr_n = 1'b1;
  endtask

  task automatic expect_grant(input int o);
    #1;
    chk("grant_gnt", 32'(gnt), 32'(oh(o)));
    chk("grant_owner", 32'(owner), 32'(o));
    chk("grant_done", 32'(burst_done), 0);
  endtask

  // Runs from a negedge where owner o holds gnt; returns at the negedge after
  // the edge that accepted word nwords (or after the cycle budget expires).
  task automatic do_burst(input int o, input int nwords, input bit gaps,
                          input int full_start, input int drop_after);
    int  writes = 0;
    int  c = 0;
    bit  v;
    bit  acc;
    while (writes < nwords && c < 400) begin
      v = gaps ? (c % 2 == 0) : 1'b1;
      src_valid = '1;
      src_valid[o] = v;
      fifo_full = (c >= full_start) && (c < full_start + 5);
      if (drop_after >= 0 && writes >= drop_after) req[o] = 1'b0;
      #1;
      chk("burst_gnt", 32'(gnt), 32'(oh(o)));
      chk("burst_ready", 32'(src_ready), fifo_full ? 0 : 32'(oh(o)));
      chk("burst_wr_en", 32'(fifo_wr_en), 32'(v & ~fifo_full));
      chk("burst_done_low", 32'(burst_done), 0);
      acc = fifo_wr_en;
      if (acc) begin
        chk("burst_data", fifo_wr_data, {8'(o), wcnt[o]});
        writes++;
      end
      @(posedge clk_wr);
      if (acc) wcnt[o] = wcnt[o] + 1'b1;
      @(negedge clk_wr);
      c++;
    end
    if (c >= 400) chk("burst_timeout", 32'(writes), 32'(nwords));
    if (!gaps && full_start < -10) chk("burst_cycles", 32'(c), 32'(nwords));
  endtask

  task automatic end_burst();
    #1;
    chk("end_gnt", 32'(gnt), 0);
    chk("end_done", 32'(burst_done), 1);
    chk("end_ready", 32'(src_ready), 0);
    chk("end_wr_en", 32'(fifo_wr_en), 0);
  endtask

  initial begin
    int order [6];
    order = '{0, 1, 3, 0, 1, 3};
    for (int i = 0; i < NR; i++) wcnt[i] = '0;
    rst_wr_n = 1'b0; req = '0; src_valid = '0; fifo_full = 1'b0; fifo_count = '0;

    // Single request, straight burst.
    reset_dut();
    req = 4'b0001;
    #1 chk("t1_no_gnt_yet", 32'(gnt), 0);
    @(negedge clk_wr);
    expect_grant(0);
    do_burst(0, BL, 1'b0, -100, 0);
    end_burst();
    @(negedge clk_wr);
    #1;
    chk("t1_done_pulse", 32'(burst_done), 0);
    chk("t1_idle_gnt", 32'(gnt), 0);

    // Three requesters held: rotation 0,1,3 with one idle cycle between bursts.
    reset_dut();
    req = 4'b1011;
    @(negedge clk_wr);
    for (int k = 0; k < 6; k++) begin
      expect_grant(order[k]);
      do_burst(order[k], BL, 1'b0, -100, -1);
      end_burst();
      if (k == 5) req = '0;
      @(negedge clk_wr);
    end
    #1 chk("t2_idle_gnt", 32'(gnt), 0);

    // Space check at the boundary, then gapped valid with a full stall.
    reset_dut();
    fifo_count = 8'd177;
    req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_wr);
      #1 chk("t3_no_space", 32'(gnt), 0);
    end
    fifo_count = 8'd176;
    @(negedge clk_wr);
    expect_grant(2);
    fifo_count = '0;
    do_burst(2, BL, 1'b1, 20, 0);
    src_valid = '1;
    end_burst();
    @(negedge clk_wr);
    #1 chk("t3_no_extra_write", 32'(fifo_wr_en), 0);
    chk("t3_gnt_after", 32'(gnt), 0);

    // Reset in the middle of a burst, then priority restarts at source 0.
    reset_dut();
    req = 4'b0001;
    @(negedge clk_wr);
    expect_grant(0);
    do_burst(0, 30, 1'b0, -100, 0);
    src_valid = '1;
    rst_wr_n = 1'b0;
    #1;
    chk("t4_rst_gnt", 32'(gnt), 0);
    chk("t4_rst_ready", 32'(src_ready), 0);
    chk("t4_rst_wr_en", 32'(fifo_wr_en), 0);
    chk("t4_rst_owner", 32'(owner), 0);
    @(negedge clk_wr);
    rst_wr_n = 1'b1;
    req = 4'b1001;
    @(negedge clk_wr);
    expect_grant(0);
    do_burst(0, BL, 1'b0, -100, 0);
    end_burst();
    @(negedge clk_wr);
    expect_grant(3);
    do_burst(3, BL, 1'b0, -100, 0);
    end_burst();

    // Owner drops req mid-burst; the burst still completes.
    reset_dut();
    req = 4'b0110;
    @(negedge clk_wr);
    expect_grant(1);
    do_burst(1, BL, 1'b0, -100, 10);
    end_burst();
    @(negedge clk_wr);
    expect_grant(2);
    do_burst(2, BL, 1'b0, -100, 0);
    end_burst();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one async_fifo write port (porta side) among NUM_REQ frame producers in the G729 encoder. Each grant covers one complete burst of BURST_LEN words (one speech frame) so frames from different sources never interleave in the FIFO. A burst is started only when the FIFO, as seen through its write-domain count, already has room for the whole frame. The block sits entirely in the FIFO write clock domain.

## Interface

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, FIFO word width
- ADDR_WIDTH, 12, FIFO address width; depth DEPTH = 2^ADDR_WIDTH
- BURST_LEN, 80, words per grant (1..DEPTH-1)

Ports:
- clk_wr  in  1  write-domain clock, same clock as the FIFO write port
- rst_wr_n  in  1  reset: rst_wr_n, asynchronous, active-low; clock clk_wr
- req  in  NUM_REQ  per-source burst request, level; held until granted
- src_valid  in  NUM_REQ  per-source data valid
- src_data  in  NUM_REQ*DATA_WIDTH  flattened source data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- src_ready  out  NUM_REQ  per-source ready; only the owner's bit can be high
- gnt  out  NUM_REQ  one-hot grant, registered
- fifo_wr_en  out  1  to FIFO write enable
- fifo_wr_data  out  DATA_WIDTH  to FIFO write data
- fifo_full  in  1  FIFO full, write domain
- fifo_count  in  ADDR_WIDTH  FIFO occupancy, write domain
- burst_done  out  1  one-cycle pulse when the last word of a burst is accepted
- owner  out  $clog2(NUM_REQ)  index of current or last owner

## Operation

- State machine states:
  - IDLE: no grant active.
  - BURST: one source owns the FIFO write port.
- space_ok = ~fifo_full & (fifo_count <= DEPTH - BURST_LEN).
  - Compare at ADDR_WIDTH+1 bits.
  - fifo_count lags reads, so this check is conservative and always safe.
- IDLE -> BURST when |req & space_ok.
  - Winner: first set req bit searching upward from (last_owner+1) mod NUM_REQ, with wrap-around.
  - Registered on that edge: gnt[winner]=1, owner=winner, beat_cnt=0.
  - If space_ok=0, stay in IDLE. Requests are never dropped.
- In BURST, for owner o:
  - src_ready[o] = ~fifo_full.
  - accept = src_valid[o] & src_ready[o].
  - fifo_wr_en = accept (combinational).
  - fifo_wr_data = src_data slice o (combinational mux).
  - Each accept increments beat_cnt. beat_cnt is $clog2(BURST_LEN+1) bits and never wraps.
- BURST -> IDLE on the accept where beat_cnt == BURST_LEN-1. On that edge:
  - gnt clears to 0.
  - last_owner = o.
  - burst_done pulses for 1 cycle.
- Request and valid handling:
  - req is ignored while in BURST. Deasserting req mid-burst does not end the burst; the source must deliver all BURST_LEN words.
  - src_valid from non-owners is ignored, and their src_ready stays 0.
- fifo_full high in BURST: src_ready=0 and fifo_wr_en=0 (stall). Not expected given the space check, but required.
- src_valid gaps stall the burst with no timeout.
- Reset values:
  - state=IDLE, gnt=0, src_ready=0, fifo_wr_en=0, burst_done=0, beat_cnt=0, owner=0.
  - last_owner=NUM_REQ-1, so source 0 has first priority after reset.
  - fifo_wr_data is don't-care while fifo_wr_en=0.
- Reset asserted mid-burst: everything returns to the reset values immediately. The partial frame stays in the FIFO; flushing it is the FIFO's srst, not this block.

## Timing

- Grant latency:
  - req high with space_ok at edge N -> gnt high after edge N.
  - The first word can be accepted in the cycle after edge N; the first fifo_wr_en is sampled at edge N+1.
- A burst with no stalls takes BURST_LEN cycles of fifo_wr_en. gnt is high for exactly BURST_LEN cycles.
- One IDLE cycle always separates consecutive bursts. Minimum period is BURST_LEN+1 cycles.
- Write path: fifo_wr_en and fifo_wr_data are combinational from src_valid, src_data and fifo_full.
- State, gnt, owner, beat_cnt and burst_done are registered.
- burst_done is high in the cycle after the last accepted word, coincident with gnt=0.

## Test plan

- Single request, BURST_LEN=80, fifo_count=0, src_valid held high -> gnt[0] one cycle after req; 80 consecutive fifo_wr_en carrying source-0 data in order; burst_done pulses once; gnt clears.
- req=4'b1011 held, after reset -> grant order 0,1,3,0,1,3; each burst is 80 words; one idle cycle between bursts.
- ADDR_WIDTH=8, fifo_count=177 (> 256-80), req[2] high -> no grant. Drop fifo_count to 176 -> gnt[2] on the next edge.
- Owner toggles src_valid every other cycle; raise fifo_full for 5 cycles mid-burst -> src_ready and fifo_wr_en low while full; still exactly 80 writes; no data lost or duplicated.
- Assert rst_wr_n low after 30 words of a burst -> gnt, src_ready and fifo_wr_en go 0 immediately. After release, req[3]/req[0] both high -> source 0 is granted first.
- Source 1 drops req after 10 words while source 2 requests -> source 1 keeps gnt until word 80; source 2 is granted after the idle cycle.
